// File: rtl/lcd_pkg.sv
// Shared DCS command codes, FSM state encoding and window helpers for the
// LCD bus to framebuffer path.
package lcd_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_IGNORE
    } state_t;

    function automatic logic [15:0] clamp_end(input logic [15:0] e, input logic [15:0] lim);
        return (e > lim) ? lim : e;
    endfunction

endpackage

// File: rtl/lcd_px_fifo.sv
// Two-entry write FIFO toward the framebuffer; a push on a full FIFO is
// accepted when the head is popped in the same cycle.
module lcd_px_fifo #(
    parameter int W = 33
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push, do_pop;

    assign o_full  = (cnt_q == 2'd2);
    assign o_empty = (cnt_q == 2'd0);
    assign o_data  = mem_q[rd_ptr_q];
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (i_flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: storage is reset too, so the output bus reads zero after reset
    // rather than X; at two entries the cost is negligible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_win_ctrl.sv
// Sequences decoded LCD bus command/parameter/pixel pulses into windowed
// framebuffer writes through a small valid/ready FIFO.
module lcd_win_ctrl
    import lcd_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int AW    = $clog2(H_RES*V_RES)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_command,
    input  logic          i_command_latch,
    input  logic [7:0]    i_param,
    input  logic          i_param_latch,
    input  logic [15:0]   i_rgb565,
    input  logic          i_rgb565_latch,
    output logic [AW-1:0] o_fb_addr,
    output logic [15:0]   o_fb_data,
    output logic          o_fb_valid,
    input  logic          i_fb_ready,
    output logic          o_frame_done,
    output logic          o_overflow,
    output logic          o_win_err
);

    localparam logic [15:0] X_MAX = 16'(H_RES - 1);
    localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

    state_t         state_q, state_d;
    logic [15:0]    xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0]    sh_start_q, sh_start_d;
    logic [7:0]     sh_end_hi_q, sh_end_hi_d;
    logic [1:0]     pidx_q, pidx_d;
    logic [15:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [AW-1:0]  row_base_q, row_base_d;
    logic           frame_done_q, frame_done_d;
    logic           overflow_q, overflow_d;
    logic           win_err_q, win_err_d;
    logic [15:0]    commit_end;

    logic           fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [AW+15:0] fifo_wdata, fifo_head;

    // Constant multiplier; synthesis reduces it to a shift-add network.
    function automatic logic [AW-1:0] row_of(input logic [15:0] y);
        return AW'(y) * AW'(H_RES);
    endfunction

    assign fifo_pop   = !fifo_empty && i_fb_ready;
    assign fifo_wdata = {row_base_q + AW'(cur_x_q), i_rgb565};
    assign commit_end = clamp_end({sh_end_hi_q, i_param}, (state_q == ST_CASET) ? X_MAX : Y_MAX);

    // NOTE: every signal gets its default before any branch, so the block
    // stays purely combinational with no inferred latches.
    always_comb begin
        state_d      = state_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        sh_start_d   = sh_start_q;
        sh_end_hi_d  = sh_end_hi_q;
        pidx_d       = pidx_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        row_base_d   = row_base_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        win_err_d    = win_err_q;
        fifo_push    = 1'b0;
        fifo_flush   = 1'b0;

        if (i_command_latch) begin
            // A command always wins; any half-received window is discarded.
            pidx_d = 2'd0;
            case (i_command)
                CMD_CASET: state_d = ST_CASET;
                CMD_PASET: state_d = ST_PASET;
                CMD_RAMWR: begin
                    state_d    = ST_RAMWR;
                    cur_x_d    = xs_q;
                    cur_y_d    = ys_q;
                    row_base_d = row_of(ys_q);
                    overflow_d = 1'b0;
                end
                CMD_RAMWRC: state_d = ST_RAMWR;
                CMD_SWRESET: begin
                    state_d    = ST_IDLE;
                    xs_d       = 16'd0;
                    xe_d       = X_MAX;
                    ys_d       = 16'd0;
                    ye_d       = Y_MAX;
                    fifo_flush = 1'b1;
                end
                default: state_d = ST_IGNORE;
            endcase
        end else begin
            if (i_param_latch && (state_q == ST_CASET || state_q == ST_PASET)) begin
                pidx_d = pidx_q + 2'd1;
                case (pidx_q)
                    2'd0: sh_start_d[15:8] = i_param;
                    2'd1: sh_start_d[7:0]  = i_param;
                    2'd2: sh_end_hi_d      = i_param;
                    default: begin
                        state_d = ST_IDLE;
                        if (sh_start_q > commit_end) begin
                            win_err_d = 1'b1;
                        end else if (state_q == ST_CASET) begin
                            xs_d = sh_start_q;
                            xe_d = commit_end;
                        end else begin
                            ys_d = sh_start_q;
                            ye_d = commit_end;
                        end
                    end
                endcase
            end
            if (i_rgb565_latch && state_q == ST_RAMWR) begin
                fifo_push    = 1'b1;
                frame_done_d = (cur_x_q == xe_q) && (cur_y_q == ye_q);
                if (fifo_full && !fifo_pop) begin
                    overflow_d = 1'b1;
                end
                if (cur_x_q == xe_q) begin
                    cur_x_d = xs_q;
                    if (cur_y_q == ye_q) begin
                        cur_y_d    = ys_q;
                        row_base_d = row_of(ys_q);
                    end else begin
                        cur_y_d    = cur_y_q + 16'd1;
                        row_base_d = row_base_q + AW'(H_RES);
                    end
                end else begin
                    cur_x_d = cur_x_q + 16'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            xs_q         <= 16'd0;
            xe_q         <= X_MAX;
            ys_q         <= 16'd0;
            ye_q         <= Y_MAX;
            sh_start_q   <= 16'd0;
            sh_end_hi_q  <= 8'd0;
            pidx_q       <= 2'd0;
            cur_x_q      <= 16'd0;
            cur_y_q      <= 16'd0;
            row_base_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            win_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            sh_start_q   <= sh_start_d;
            sh_end_hi_q  <= sh_end_hi_d;
            pidx_q       <= pidx_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            row_base_q   <= row_base_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            win_err_q    <= win_err_d;
        end
    end

    lcd_px_fifo #(.W(AW + 16)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_data  (fifo_wdata),
        .i_pop   (fifo_pop),
        .i_flush (fifo_flush),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_fb_addr    = fifo_head[AW+15:16];
    assign o_fb_data    = fifo_head[15:0];
    assign o_fb_valid   = !fifo_empty;
    assign o_frame_done = frame_done_q;
    assign o_overflow   = overflow_q;
    assign o_win_err    = win_err_q;

endmodule
